uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two byte-stream requesters.
// A granted requester keeps the transmitter until it delivers a byte marked last.
// Build option UART_ARB_RR_EN: round-robin between simultaneous requesters.
// When it is undefined, requester 0 has fixed priority and there is no pointer flop.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | transmitter free, grant = 00, pick a winner if any valid
// ST_GRANT     | owner may hand over a byte while the transmitter is idle
// ST_START     | one-cycle tx_start pulse for the captured byte
// ST_WAIT_ACK  | wait for the transmitter to drop tx_ready (byte taken)
// ST_WAIT_DONE | wait for tx_ready to return; release on the last byte
module uart_tx_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [1:0] req_last,
    output logic [1:0] req_ready,
    output logic [1:0] grant,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       last_q, last_d;

    logic [1:0] winner;
    logic       accept;
    logic       release_grant;
    logic [7:0] sel_data;
    logic       sel_last;

    assign sel_data      = grant_q[1] ? req_data1 : req_data0;
    assign sel_last      = |(req_last & grant_q);
    assign accept        = (state_q == ST_GRANT) && (|(req_valid & req_ready));
    assign release_grant = (state_q == ST_WAIT_DONE) && tx_ready && last_q;

`ifdef UART_ARB_RR_EN
    // ptr_q = 1 favours requester 1 when both are valid
    logic ptr_q, ptr_d;

    // Pick the winner, letting the pointer break ties
    always_comb begin
        winner = 2'b00;
        case (req_valid)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = ptr_q ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

    // On release, favour the requester that was not just served
    always_comb begin
        ptr_d = ptr_q;
        if (release_grant) begin
            ptr_d = grant_q[0];
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: requester 0 wins any tie
    always_comb begin
        winner = 2'b00;
        if (req_valid[0]) begin
            winner = 2'b01;
        end else if (req_valid[1]) begin
            winner = 2'b10;
        end
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            tx_data_q <= 8'h00;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
        end
    end

    // Next-state, grant and byte capture
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = winner;
                if (|req_valid) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    if (last_q) begin
                        grant_d = 2'b00;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        req_ready = 2'b00;
        if (state_q == ST_GRANT) begin
            req_ready = grant_q & {2{tx_ready}};
        end
        tx_start = (state_q == ST_START);
        busy     = (state_q != ST_IDLE);
        grant    = grant_q;
        tx_data  = tx_data_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART transmitter model.
module tb_uart_tx_arbiter;

    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] req_last;
    logic [1:0] req_ready;
    logic [1:0] grant;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;

    logic       model_en = 1'b1;
    logic       model_ready = 1'b1;
    logic       tb_ready = 1'b1;
    int         model_cnt = 0;
    int         model_seen = 0;

    int         total = 0;
    int         bad = 0;
    int         start_count = 0;
    logic [1:0] grant_log[$];
    logic [7:0] data_log[$];

    assign tx_ready = model_en ? model_ready : tb_ready;

    uart_tx_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Record every start pulse with the owner and byte seen alongside it
    always @(negedge clk) begin
        if (tx_start) begin
            start_count++;
            grant_log.push_back(grant);
            data_log.push_back(tx_data);
        end
    end

    // Transmitter model: goes busy after each start pulse for HOLD cycles
    always @(posedge clk) begin
        #1;
        if (reset) begin
            model_ready = 1'b1;
            model_cnt   = 0;
            model_seen  = start_count;
        end else if (model_seen != start_count) begin
            model_seen  = start_count;
            model_ready = 1'b0;
            model_cnt   = HOLD;
        end else if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) model_ready = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        req_last  = 2'b00;
        req_data0 = 8'h00;
        req_data1 = 8'h00;
        tb_ready  = 1'b1;
        model_en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Offer one byte from requester idx and wait (bounded) for it to be accepted.
    // Returns at posedge+1 of the accepting edge, with that requester's valid dropped.
    task automatic send_byte(input int idx, input logic [7:0] d, input logic l);
        int n;
        n = 0;
        if (idx == 0) req_data0 = d;
        else          req_data1 = d;
        req_last[idx]  = l;
        req_valid[idx] = 1'b1;
        @(negedge clk);
        while (!req_ready[idx] && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req_ready[idx] !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout req%0d: req_ready=%b, required bit %0d set", idx, req_ready, idx);
        end
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_release(input string tag);
        int n;
        n = 0;
        while (grant !== 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (grant !== 2'b00) begin
            bad++;
            $display("FAIL %s release_timeout: grant=%b required 00", tag, grant);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        req_last  = 2'b00;
        req_data0 = 8'h00;
        req_data1 = 8'h00;
        @(negedge clk);
        total++; if (grant !== 2'b00)     begin bad++; $display("FAIL rst_grant: got %b required 00", grant); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready: got %b required 00", req_ready); end
        total++; if (tx_start !== 1'b0)   begin bad++; $display("FAIL rst_tx_start: got %b required 0", tx_start); end
        total++; if (tx_data !== 8'h00)   begin bad++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({grant, busy} !== 3'b000) begin
            bad++;
            $display("FAIL idle_hold: grant=%b busy=%b required 00/0", grant, busy);
        end
    endtask

    task automatic test_single_burst();
        int s0;
        s0 = start_count;
        send_byte(0, 8'hA5, 1'b1);
        @(negedge clk);
        total++;
        if ({tx_start, tx_data, grant} !== {1'b1, 8'hA5, 2'b01}) begin
            bad++;
            $display("FAIL single_start: tx_start=%b tx_data=%h grant=%b required 1/a5/01", tx_start, tx_data, grant);
        end
        @(negedge clk);
        total++;
        if ({tx_start, tx_data} !== {1'b0, 8'hA5}) begin
            bad++;
            $display("FAIL single_pulse_width: tx_start=%b tx_data=%h required 0/a5", tx_start, tx_data);
        end
        wait_release("single");
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b required 0", busy); end
        total++;
        if (start_count - s0 != 1) begin
            bad++;
            $display("FAIL single_start_count: got %0d required 1", start_count - s0);
        end
    endtask

    task automatic test_multi_burst();
        logic [7:0] bytes [3];
        int n;
        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        bytes[2] = 8'h33;
        do_reset();
        req_data1    = 8'h11;
        req_last[1]  = 1'b0;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_data0    = 8'h55;
        req_last[0]  = 1'b1;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_byte(1, bytes[i], (i == 2));
            @(negedge clk);
            total++;
            if ({tx_start, tx_data, grant} !== {1'b1, bytes[i], 2'b10}) begin
                bad++;
                $display("FAIL multi_byte%0d: tx_start=%b tx_data=%h grant=%b required 1/%h/10",
                         i, tx_start, tx_data, grant, bytes[i]);
            end
        end
        n = 0;
        while (grant !== 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (grant !== 2'b00) begin
            bad++;
            $display("FAIL multi_release: grant=%b required 00 for one idle cycle", grant);
        end
        @(negedge clk);
        total++;
        if (grant !== 2'b01) begin
            bad++;
            $display("FAIL multi_next_grant: grant=%b required 01 right after the idle cycle", grant);
        end
        send_byte(0, 8'h55, 1'b1);
        @(negedge clk);
        total++;
        if ({tx_start, tx_data} !== {1'b1, 8'h55}) begin
            bad++;
            $display("FAIL multi_req0_byte: tx_start=%b tx_data=%h required 1/55", tx_start, tx_data);
        end
        wait_release("multi");
    endtask

    task automatic test_contention();
        int         base;
        int         n;
        logic [1:0] exp_g;
        logic [7:0] exp_d;
        do_reset();
        req_data0 = 8'hA0;
        req_data1 = 8'hB0;
        req_last  = 2'b11;
        base      = grant_log.size();
        req_valid = 2'b11;
        n = 0;
        while (grant_log.size() < base + 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (grant_log.size() < base + 4) begin
            bad++;
            $display("FAIL contention_timeout: starts=%0d required 4", grant_log.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            if (base + i < grant_log.size()) begin
`ifdef UART_ARB_RR_EN
                exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
                exp_g = 2'b01;
`endif
                exp_d = (exp_g == 2'b01) ? 8'hA0 : 8'hB0;
                total++;
                if ({grant_log[base+i], data_log[base+i]} !== {exp_g, exp_d}) begin
                    bad++;
                    $display("FAIL contention_%0d: grant=%b data=%h required %b/%h",
                             i, grant_log[base+i], data_log[base+i], exp_g, exp_d);
                end
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        do_reset();
        model_en  = 1'b0;
        tb_ready  = 1'b0;
        req_data0 = 8'h3C;
        req_last  = 2'b01;
        req_valid = 2'b01;
        repeat (3) @(negedge clk);
        total++;
        if ({grant, req_ready, tx_start, busy} !== {2'b01, 2'b00, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL bp_stalled: grant=%b req_ready=%b tx_start=%b busy=%b required 01/00/0/1",
                     grant, req_ready, tx_start, busy);
        end
        tb_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL bp_ready_follow: req_ready=%b required 01", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        total++;
        if ({tx_start, tx_data} !== {1'b1, 8'h3C}) begin
            bad++;
            $display("FAIL bp_start: tx_start=%b tx_data=%h required 1/3c", tx_start, tx_data);
        end
        tb_ready = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({tx_start, busy, grant} !== {1'b0, 1'b1, 2'b01}) begin
            bad++;
            $display("FAIL bp_wait_done: tx_start=%b busy=%b grant=%b required 0/1/01", tx_start, busy, grant);
        end
        tb_ready = 1'b1;
        wait_release("bp");
        model_en = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        int s0;
        do_reset();
        send_byte(0, 8'hC3, 1'b1);
        @(negedge clk);
        total++;
        if ({tx_start, tx_data} !== {1'b1, 8'hC3}) begin
            bad++;
            $display("FAIL rmid_start: tx_start=%b tx_data=%h required 1/c3", tx_start, tx_data);
        end
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({grant, req_ready, tx_start, tx_data, busy} !== {2'b00, 2'b00, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL rmid_async: grant=%b req_ready=%b tx_start=%b tx_data=%h busy=%b required 00/00/0/00/0",
                     grant, req_ready, tx_start, tx_data, busy);
        end
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        s0 = start_count;
        repeat (30) @(negedge clk);
        total++;
        if ({start_count - s0, busy} !== {32'd0, 1'b0}) begin
            bad++;
            $display("FAIL rmid_no_start: starts=%0d busy=%b required 0/0", start_count - s0, busy);
        end
    endtask

    task automatic test_stall_in_grant();
        int s0;
        int n;
        do_reset();
        req_data0 = 8'h77;
        req_last  = 2'b01;
        req_valid = 2'b01;
        n = 0;
        @(negedge clk);
        while (grant !== 2'b01 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (grant !== 2'b01) begin
            bad++;
            $display("FAIL stall_grant: grant=%b required 01", grant);
        end
        req_valid = 2'b10;
        req_data1 = 8'h88;
        req_last  = 2'b11;
        s0 = start_count;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({grant, tx_start, busy} !== 4'b0101) begin
                bad++;
                $display("FAIL stall_cycle%0d: grant=%b tx_start=%b busy=%b required 01/0/1", i, grant, tx_start, busy);
            end
        end
        total++;
        if (start_count != s0) begin
            bad++;
            $display("FAIL stall_starts: got %0d required 0", start_count - s0);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        test_stall_in_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
